// File: rtl/bit_serializer_pkg.sv
// Shared types and default parameters for the bit serializer.
package bit_serializer_pkg;

  // Two-state shifter control: waiting for a word, or streaming one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int   DefaultWidth   = 8;
  localparam logic DefaultIdleBit = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready and streams one
// bit per clock onto dout, with a one-word hold buffer so consecutive words
// leave back to back without an idle cycle between them.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = DefaultWidth,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = DefaultIdleBit
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             holdValid_q, holdValid_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             doutValid_q, doutValid_d;
  logic             frameStart_q, frameStart_d;
  logic             busy_q, busy_d;

  logic             transfer;
  logic             loadEn;
  logic [WIDTH-1:0] loadWord;

  // The bit of a word that goes out first in the configured send order.
  function automatic logic firstBit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-1];
    else                return w[0];
  endfunction

  // Drop the bit just sent so the next one sits in the "first" position.
  function automatic logic [WIDTH-1:0] shiftWord(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return {w[WIDTH-2:0], 1'b0};
    else                return {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready depends only on the hold register, never on data_valid.
  assign data_ready = !holdValid_q;
  assign transfer   = data_valid && data_ready;

  // Next-state logic: decide whether a word starts, the current word advances,
  // or the shifter drains back to idle; word starts share one load path.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    holdValid_d  = holdValid_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    doutValid_d  = doutValid_q;
    frameStart_d = 1'b0;
    loadEn       = 1'b0;
    loadWord     = data_in;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          loadEn = 1'b1;
        end else begin
          dout_d      = IDLE_BIT;
          doutValid_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == LastCnt) begin
          if (holdValid_q) begin
            loadEn      = 1'b1;
            loadWord    = hold_q;
            holdValid_d = 1'b0;
          end else if (transfer) begin
            loadEn = 1'b1;
          end else begin
            state_d     = IDLE;
            dout_d      = IDLE_BIT;
            doutValid_d = 1'b0;
          end
        end else begin
          dout_d  = firstBit(shift_q);
          shift_d = shiftWord(shift_q);
          cnt_d   = cnt_q + CntW'(1);
          if (transfer) begin
            hold_d      = data_in;
            holdValid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (loadEn) begin
      shift_d      = shiftWord(loadWord);
      dout_d       = firstBit(loadWord);
      doutValid_d  = 1'b1;
      frameStart_d = 1'b1;
      cnt_d        = '0;
      state_d      = SHIFT;
    end

    busy_d = (state_d == SHIFT) || holdValid_d;
  end

  // State and registered outputs; reset discards any word in flight or held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      holdValid_q  <= 1'b0;
      cnt_q        <= '0;
      dout_q       <= IDLE_BIT;
      doutValid_q  <= 1'b0;
      frameStart_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      holdValid_q  <= holdValid_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      doutValid_q  <= doutValid_d;
      frameStart_q <= frameStart_d;
      busy_q       <= busy_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = doutValid_q;
  assign frame_start = frameStart_q;
  assign busy        = busy_q;

endmodule
